// File: rtl/regbus_master.sv
// Register-bus master: turns one command into a single bus write or a read
// with timeout, then holds the response until the consumer takes it.
module regbus_master #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  chip_select,
  output logic                  write_en,
  output logic                  read_en,
  output logic [DATA_WIDTH-1:0] write_data,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic                  data_valid,
  output logic                  busy
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic                    cmd_ready_nxt, busy_nxt;
  logic                    rsp_valid_nxt, rsp_error_nxt;
  logic [DATA_WIDTH-1:0]   rsp_rdata_nxt, write_data_nxt;
  logic [ADDR_WIDTH-1:0]   addr_nxt;
  logic                    chip_select_nxt, write_en_nxt, read_en_nxt;

  // State, timeout counter and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_error   <= 1'b0;
      rsp_rdata   <= '0;
      addr        <= '0;
      write_data  <= '0;
      chip_select <= 1'b0;
      write_en    <= 1'b0;
      read_en     <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      cmd_ready   <= cmd_ready_nxt;
      busy        <= busy_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_error   <= rsp_error_nxt;
      rsp_rdata   <= rsp_rdata_nxt;
      addr        <= addr_nxt;
      write_data  <= write_data_nxt;
      chip_select <= chip_select_nxt;
      write_en    <= write_en_nxt;
      read_en     <= read_en_nxt;
    end
  end

  // Next state and next values of the registered outputs
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    rsp_valid_nxt   = rsp_valid;
    rsp_error_nxt   = rsp_error;
    rsp_rdata_nxt   = rsp_rdata;
    addr_nxt        = addr;
    write_data_nxt  = write_data;
    chip_select_nxt = chip_select;
    write_en_nxt    = write_en;
    read_en_nxt     = read_en;

    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          // The output registers double as the latched command
          state_nxt       = cmd_write ? WRITE : READ;
          cnt_nxt         = '0;
          addr_nxt        = cmd_addr;
          write_data_nxt  = cmd_write ? cmd_wdata : '0;
          chip_select_nxt = 1'b1;
          write_en_nxt    = cmd_write;
          read_en_nxt     = ~cmd_write;
        end
      end
      WRITE: begin
        state_nxt       = RESP;
        addr_nxt        = '0;
        write_data_nxt  = '0;
        chip_select_nxt = 1'b0;
        write_en_nxt    = 1'b0;
        read_en_nxt     = 1'b0;
        rsp_valid_nxt   = 1'b1;
        rsp_rdata_nxt   = '0;
        rsp_error_nxt   = 1'b0;
      end
      READ: begin
        // data_valid wins over an expiring timeout
        if (data_valid || (cnt == CNT_LAST)) begin
          state_nxt       = RESP;
          addr_nxt        = '0;
          write_data_nxt  = '0;
          chip_select_nxt = 1'b0;
          write_en_nxt    = 1'b0;
          read_en_nxt     = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_rdata_nxt   = data_valid ? read_data : '0;
          rsp_error_nxt   = ~data_valid;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt     = IDLE;
          rsp_valid_nxt = 1'b0;
          rsp_rdata_nxt = '0;
          rsp_error_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase

    cmd_ready_nxt = (state_nxt == IDLE);
    busy_nxt      = (state_nxt != IDLE);
  end

endmodule
